// File: rtl/pid_loop_sequencer_if.sv
// rtl/pid_loop_sequencer_if.sv - sensor handshake and PID datapath signals around the loop sequencer
interface pid_loop_sequencer_if;
  logic               sensor_req;
  logic               sensor_ack;
  logic signed [15:0] sensor_data;
  logic signed [15:0] pid_set_temp;
  logic signed [15:0] pid_curr_temp;
  logic               pid_step;
  logic signed [15:0] pid_control;

  modport master (
    output sensor_req, pid_set_temp, pid_curr_temp, pid_step,
    input  sensor_ack, sensor_data, pid_control
  );

  modport slave (
    input  sensor_req, pid_set_temp, pid_curr_temp, pid_step,
    output sensor_ack, sensor_data, pid_control
  );
endinterface

// File: rtl/pid_loop_sequencer.sv
// rtl/pid_loop_sequencer.sv - one PID control iteration per sample period: sensor request, PID step, duty update
module pid_loop_sequencer #(
  parameter int SAMPLE_PERIOD = 100000,
  parameter int PID_LAT       = 3,
  parameter int TIMEOUT       = 1000,
  parameter int MAX_FAULTS    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 fault_clr_i,
  input  logic signed [15:0]   set_temp_i,
  pid_loop_sequencer_if.master loop_if,
  output logic [15:0]          duty_out_o,
  output logic                 duty_valid_o,
  output logic                 fault_o,
  output logic                 overrun_o
);
  localparam int TICK_W = $clog2(SAMPLE_PERIOD);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int SET_W  = $clog2(PID_LAT + 1);
  localparam int FLT_W  = $clog2(MAX_FAULTS + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_TICK, ST_REQ, ST_STEP, ST_SETTLE, ST_UPDATE, ST_FAULT
  } state_t;

  state_t             state_q;
  logic [TICK_W-1:0]  tick_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [SET_W-1:0]   settle_q;
  logic [FLT_W-1:0]   fault_cnt_q;
  logic               sensor_req_q;
  logic               pid_step_q;
  logic               duty_valid_q;
  logic               fault_q;
  logic               overrun_q;
  logic signed [15:0] pid_set_q;
  logic signed [15:0] pid_curr_q;
  logic [15:0]        duty_q;

  logic               tick_run;
  logic               tick;
  logic               busy;
  logic [15:0]        duty_clamped;

  assign tick_run     = enable_i && (state_q != ST_FAULT);
  assign tick         = tick_run && (tick_q == TICK_W'(SAMPLE_PERIOD - 1));
  assign busy         = (state_q == ST_REQ) || (state_q == ST_STEP) ||
                        (state_q == ST_SETTLE) || (state_q == ST_UPDATE);
  assign duty_clamped = loop_if.pid_control[15] ? 16'd0 : $unsigned(loop_if.pid_control);

  // SETTLE spans PID_LAT-1 cycles so the duty_valid of UPDATE lands PID_LAT cycles after pid_step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      tmo_q        <= '0;
      settle_q     <= '0;
      fault_cnt_q  <= '0;
      sensor_req_q <= 1'b0;
      pid_step_q   <= 1'b0;
      duty_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      overrun_q    <= 1'b0;
      pid_set_q    <= '0;
      pid_curr_q   <= '0;
      duty_q       <= '0;
    end else begin
      pid_step_q   <= 1'b0;
      duty_valid_q <= 1'b0;
      tick_q       <= (!tick_run || tick) ? '0 : tick_q + 1'b1;
      if (tick && busy)
        overrun_q <= 1'b1;
      if (fault_clr_i)
        overrun_q <= 1'b0;

      if (!enable_i && state_q != ST_FAULT) begin
        state_q      <= ST_IDLE;
        sensor_req_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_WAIT_TICK;
          ST_WAIT_TICK: begin
            if (tick) begin
              state_q      <= ST_REQ;
              sensor_req_q <= 1'b1;
              tmo_q        <= '0;
            end
          end
          ST_REQ: begin
            if (loop_if.sensor_ack) begin
              pid_curr_q   <= loop_if.sensor_data;
              pid_set_q    <= set_temp_i;
              sensor_req_q <= 1'b0;
              fault_cnt_q  <= '0;
              pid_step_q   <= 1'b1;
              state_q      <= ST_STEP;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
              sensor_req_q <= 1'b0;
              fault_cnt_q  <= fault_cnt_q + 1'b1;
              if (fault_cnt_q == FLT_W'(MAX_FAULTS - 1)) begin
                state_q <= ST_FAULT;
                fault_q <= 1'b1;
                duty_q  <= '0;
              end else begin
                state_q <= ST_WAIT_TICK;
              end
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          ST_STEP: begin
            settle_q <= SET_W'(1);
            if (PID_LAT == 1) begin
              duty_q       <= duty_clamped;
              duty_valid_q <= 1'b1;
              state_q      <= ST_UPDATE;
            end else begin
              state_q <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (settle_q == SET_W'(PID_LAT - 1)) begin
              duty_q       <= duty_clamped;
              duty_valid_q <= 1'b1;
              state_q      <= ST_UPDATE;
            end else begin
              settle_q <= settle_q + 1'b1;
            end
          end
          ST_UPDATE: state_q <= ST_WAIT_TICK;
          ST_FAULT: begin
            if (fault_clr_i) begin
              state_q     <= ST_IDLE;
              fault_q     <= 1'b0;
              fault_cnt_q <= '0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign loop_if.sensor_req    = sensor_req_q;
  assign loop_if.pid_step      = pid_step_q;
  assign loop_if.pid_set_temp  = pid_set_q;
  assign loop_if.pid_curr_temp = pid_curr_q;
  assign duty_out_o            = duty_q;
  assign duty_valid_o          = duty_valid_q;
  assign fault_o               = fault_q;
  assign overrun_o             = overrun_q;
endmodule

// File: tb/tb_pid_loop_sequencer.sv
// tb/tb_pid_loop_sequencer.sv - self-checking bench for pid_loop_sequencer
module tb_pid_loop_sequencer;
  localparam int SP    = 20;
  localparam int LAT   = 3;
  localparam int TMO_A = 8;
  localparam int TMO_B = 30;
  localparam int MAXF  = 3;

  logic clk = 1'b0;
  logic reset;
  logic enable, fault_clr, ack;
  logic signed [15:0] set_temp, sdata, ctrl;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int step_cnt = 0;
  bit sel = 1'b0;
  int pat[$];

  pid_loop_sequencer_if if_a ();
  pid_loop_sequencer_if if_b ();

  logic [15:0] duty_a, duty_b;
  logic dv_a, dv_b, flt_a, flt_b, ovr_a, ovr_b;

  assign if_a.sensor_ack  = ack;
  assign if_a.sensor_data = sdata;
  assign if_a.pid_control = ctrl;
  assign if_b.sensor_ack  = ack;
  assign if_b.sensor_data = sdata;
  assign if_b.pid_control = ctrl;

  pid_loop_sequencer #(.SAMPLE_PERIOD(SP), .PID_LAT(LAT), .TIMEOUT(TMO_A), .MAX_FAULTS(MAXF)) dut_a (
    .clk(clk), .reset(reset), .enable_i(enable), .fault_clr_i(fault_clr), .set_temp_i(set_temp),
    .loop_if(if_a), .duty_out_o(duty_a), .duty_valid_o(dv_a), .fault_o(flt_a), .overrun_o(ovr_a)
  );

  pid_loop_sequencer #(.SAMPLE_PERIOD(SP), .PID_LAT(LAT), .TIMEOUT(TMO_B), .MAX_FAULTS(MAXF)) dut_b (
    .clk(clk), .reset(reset), .enable_i(enable), .fault_clr_i(fault_clr), .set_temp_i(set_temp),
    .loop_if(if_b), .duty_out_o(duty_b), .duty_valid_o(dv_b), .fault_o(flt_b), .overrun_o(ovr_b)
  );

  // Observed view of whichever instance the current scenario targets.
  logic m_req, m_step, m_dv, m_flt, m_ovr;
  logic [15:0] m_duty;
  logic signed [15:0] m_pset, m_pcur;
  assign m_req  = sel ? if_b.sensor_req    : if_a.sensor_req;
  assign m_step = sel ? if_b.pid_step      : if_a.pid_step;
  assign m_pset = sel ? if_b.pid_set_temp  : if_a.pid_set_temp;
  assign m_pcur = sel ? if_b.pid_curr_temp : if_a.pid_curr_temp;
  assign m_dv   = sel ? dv_b  : dv_a;
  assign m_flt  = sel ? flt_b : flt_a;
  assign m_ovr  = sel ? ovr_b : ovr_a;
  assign m_duty = sel ? duty_b : duty_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (m_step === 1'b1) step_cnt++;

  function automatic logic [15:0] clamp(input logic signed [15:0] v);
    if (v < 0) return 16'd0;
    return $unsigned(v);
  endfunction

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; fault_clr = 1'b0; ack = 1'b0;
    set_temp = '0; sdata = '0; ctrl = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_req_at(input int exp_cyc, input string nm, output int r);
    int n = 0;
    while (m_req !== 1'b1 && n < 4 * SP) begin
      @(negedge clk);
      n++;
    end
    r = cyc;
    checks++;
    if (m_req !== 1'b1 || cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s: sensor_req=%b at cycle %0d, required rise at cycle %0d", nm, m_req, cyc, exp_cyc);
    end
  endtask

  task automatic start_loop(output int r);
    int e;
    enable = 1'b1;
    e = cyc;
    @(negedge clk);
    wait_req_at(e + SP, "first_req", r);
  endtask

  // Entered on the first cycle of sensor_req; ack lands on REQ cycle d.
  task automatic run_iter(input int r, input int d, input logic signed [15:0] sp,
                          input logic signed [15:0] data, input logic signed [15:0] c,
                          input int gap, output int r_next);
    bit hold_ok = 1'b1;
    bit stable_ok = 1'b1;
    set_temp = sp;
    ctrl = c;
    for (int k = 1; k <= d; k++) begin
      if (m_req !== 1'b1 || m_step !== 1'b0) hold_ok = 1'b0;
      ack = (k == d);
      sdata = (k == d) ? data : 16'($urandom);
      @(negedge clk);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL req_hold: sensor_req not held for %0d cycles before ack (req_start=%0d)", d, r);
    end
    checks++;
    if ({m_req, m_step, m_dv} !== 3'b010) begin
      errors++;
      $display("FAIL step_pulse: req/step/valid=%b required 010 at cycle %0d", {m_req, m_step, m_dv}, cyc);
    end
    checks++;
    if (m_pset !== sp || m_pcur !== data) begin
      errors++;
      $display("FAIL pid_inputs: set=%0d curr=%0d required set=%0d curr=%0d", m_pset, m_pcur, sp, data);
    end
    for (int j = 1; j < LAT; j++) begin
      ack = 1'($urandom_range(0, 1));
      sdata = 16'($urandom);
      set_temp = 16'($urandom);
      @(negedge clk);
      if ({m_req, m_step, m_dv} !== 3'b000 || m_pset !== sp || m_pcur !== data) stable_ok = 1'b0;
    end
    ack = 1'b0;
    @(negedge clk);
    if (m_step !== 1'b0 || m_pset !== sp || m_pcur !== data) stable_ok = 1'b0;
    checks++;
    if (m_dv !== 1'b1 || m_duty !== clamp(c)) begin
      errors++;
      $display("FAIL duty_update: valid=%b duty=%0d required valid=1 duty=%0d", m_dv, m_duty, clamp(c));
    end
    checks++;
    if (!stable_ok) begin
      errors++;
      $display("FAIL settle_stable: pid inputs or strobes disturbed during settle (set=%0d curr=%0d)", m_pset, m_pcur);
    end
    @(negedge clk);
    checks++;
    if (m_dv !== 1'b0) begin
      errors++;
      $display("FAIL valid_width: duty_valid=%b required 0 one cycle after update", m_dv);
    end
    wait_req_at(r + gap, "next_req", r_next);
  endtask

  task automatic timeout_iter(input int r, input int tmo, input bit exp_fault, output int r_next);
    bit hold_ok = 1'b1;
    ack = 1'b0;
    for (int k = 1; k <= tmo; k++) begin
      if (m_req !== 1'b1) hold_ok = 1'b0;
      sdata = 16'($urandom);
      @(negedge clk);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL tmo_req_hold: sensor_req not held for %0d cycles (req_start=%0d)", tmo, r);
    end
    checks++;
    if ({m_req, m_step, m_dv, m_flt} !== {3'b000, exp_fault}) begin
      errors++;
      $display("FAIL tmo_drop: req/step/valid/fault=%b required %b", {m_req, m_step, m_dv, m_flt}, {3'b000, exp_fault});
    end
    r_next = r;
    if (exp_fault) begin
      checks++;
      if (m_duty !== 16'd0) begin
        errors++;
        $display("FAIL fault_duty: duty=%0d required 0 on fault entry", m_duty);
      end
    end else begin
      wait_req_at(r + SP, "tmo_next_req", r_next);
    end
  endtask

  // pat entries: 0 = let the request time out, n>0 = ack on REQ cycle n.
  task automatic run_pattern(inout int r);
    int consec = 0;
    foreach (pat[i]) begin
      if (pat[i] == 0) begin
        consec++;
        timeout_iter(r, TMO_A, consec == MAXF, r);
      end else begin
        consec = 0;
        run_iter(r, pat[i], 16'($urandom), 16'($urandom), 16'($urandom_range(1, 32767)), SP, r);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; fault_clr = 1'b0; ack = 1'b0;
    set_temp = 16'sd77; sdata = 16'sd88; ctrl = 16'sd99;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_a.sensor_req, if_a.pid_step, if_a.pid_set_temp, if_a.pid_curr_temp, duty_a, dv_a, flt_a, ovr_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: outputs not all zero in reset (duty=%0d req=%b)", duty_a, if_a.sensor_req);
    end
    checks++;
    if ({if_b.sensor_req, if_b.pid_step, if_b.pid_set_temp, if_b.pid_curr_temp, duty_b, dv_b, flt_b, ovr_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: outputs not all zero in reset (duty=%0d req=%b)", duty_b, if_b.sensor_req);
    end
    reset = 1'b0;
    repeat (3 * SP) @(negedge clk);
    checks++;
    if (m_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: sensor_req=%b required 0 with enable low", m_req);
    end
  endtask

  task automatic test_nominal();
    int r;
    do_reset();
    sel = 1'b0;
    start_loop(r);
    run_iter(r, 2, 16'sd500, 16'sd480, 16'sd20, SP, r);
    run_iter(r, 2, 16'sd500, 16'sd480, 16'sd20, SP, r);
    run_iter(r, 3, 16'sd500, 16'sd480, -16'sd150, SP, r);
  endtask

  task automatic test_random();
    int r;
    do_reset();
    sel = 1'b0;
    start_loop(r);
    repeat (8)
      run_iter(r, $urandom_range(1, TMO_A), 16'($urandom), 16'($urandom), 16'($urandom), SP, r);
  endtask

  task automatic test_timeout_fault();
    int r, f;
    bit quiet_ok = 1'b1;
    do_reset();
    sel = 1'b0;
    start_loop(r);
    pat = '{0, 0, 3, 0, 0, 0};
    run_pattern(r);
    for (int i = 0; i < 2 * SP; i++) begin
      @(negedge clk);
      if (m_req !== 1'b0 || m_step !== 1'b0 || m_flt !== 1'b1 || m_dv !== 1'b0) quiet_ok = 1'b0;
    end
    checks++;
    if (!quiet_ok) begin
      errors++;
      $display("FAIL fault_hold: activity or fault drop while in fault (req=%b fault=%b)", m_req, m_flt);
    end
    f = cyc;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    checks++;
    if (m_flt !== 1'b0) begin
      errors++;
      $display("FAIL fault_clr: fault=%b required 0 after fault_clr", m_flt);
    end
    wait_req_at(f + 1 + SP, "resume_req", r);
    run_iter(r, 2, 16'sd500, 16'sd480, 16'sd20, SP, r);
  endtask

  task automatic test_collision();
    int r;
    do_reset();
    sel = 1'b0;
    start_loop(r);
    pat = '{0, 0, TMO_A, 0, 0, TMO_A, 0, 0, 0};
    run_pattern(r);
  endtask

  task automatic test_overrun();
    int r, s0;
    do_reset();
    sel = 1'b1;
    start_loop(r);
    s0 = step_cnt;
    run_iter(r, 19, 16'sd400, 16'sd390, 16'sd100, 2 * SP, r);
    checks++;
    if (m_ovr !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: overrun=%b required 1 after late ack", m_ovr);
    end
    repeat (3)
      run_iter(r, $urandom_range(1, 8), 16'($urandom), 16'($urandom), 16'($urandom), SP, r);
    checks++;
    if (m_ovr !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: overrun=%b required 1 after good iterations", m_ovr);
    end
    checks++;
    if (step_cnt - s0 != 4) begin
      errors++;
      $display("FAIL step_count: %0d pid_step pulses, required 4", step_cnt - s0);
    end
    sel = 1'b0;
  endtask

  task automatic test_disable();
    int r, e;
    bit quiet_ok = 1'b1;
    do_reset();
    sel = 1'b0;
    start_loop(r);
    run_iter(r, 2, 16'sd300, 16'sd290, 16'sd1234, SP, r);
    ack = 1'b0;
    @(negedge clk);
    ack = 1'b1; sdata = 16'sd100; set_temp = 16'sd55;
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if ({m_req, m_step} !== 2'b01 || m_pcur !== 16'sd100) begin
      errors++;
      $display("FAIL dis_step: req/step=%b curr=%0d required 01 curr=100", {m_req, m_step}, m_pcur);
    end
    @(negedge clk);
    enable = 1'b0;
    ctrl = 16'sd777;
    for (int i = 0; i < 2 * SP; i++) begin
      @(negedge clk);
      if (m_dv !== 1'b0 || m_duty !== 16'd1234 || m_req !== 1'b0 || m_step !== 1'b0) quiet_ok = 1'b0;
    end
    checks++;
    if (!quiet_ok) begin
      errors++;
      $display("FAIL dis_abandon: duty=%0d valid=%b req=%b required duty=1234 valid=0 req=0", m_duty, m_dv, m_req);
    end
    e = cyc;
    enable = 1'b1;
    @(negedge clk);
    wait_req_at(e + SP, "reenable_req", r);
    run_iter(r, 1, 16'sd10, 16'sd9, 16'sd42, SP, r);
  endtask

  task automatic test_async_reset();
    int r;
    do_reset();
    sel = 1'b0;
    start_loop(r);
    run_iter(r, 1, 16'sd11, 16'sd22, 16'sd333, SP, r);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({m_req, m_step, m_dv, m_flt, m_ovr, m_duty, m_pset, m_pcur} !== '0) begin
      errors++;
      $display("FAIL async_reset: req=%b duty=%0d set=%0d curr=%0d required all zero", m_req, m_duty, m_pset, m_pcur);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_random();
    test_timeout_fault();
    test_collision();
    test_overrun();
    test_disable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: summary not reached by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/pid_loop_sequencer.md
Name: pid_loop_sequencer

Overview:
Sequences one control iteration of the temperature PID loop per sample period. It requests a sensor reading via req/ack handshake, latches setpoint and reading into stable PID inputs, and issues a single PID step pulse. After a fixed settle latency it captures the PID output as the new heater duty. It sits between the sensor interface, the PID datapath and the PWM/heater driver, and owns sensor-timeout fault handling.

Parameters:
SAMPLE_PERIOD, 100000, clk cycles per control iteration (>=16)
PID_LAT, 3, cycles from pid_step pulse until pid_control is valid (>=1)
TIMEOUT, 1000, max cycles in REQ waiting for sensor_ack
MAX_FAULTS, 3, consecutive timeouts that force FAULT state (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  loop run enable
fault_clr  in  1  one-cycle pulse; leaves FAULT
set_temp_in  in  16 signed  requested setpoint
sensor_req  out  1  sensor sample request (level)
sensor_ack  in  1  sensor data valid strobe
sensor_data  in  16 signed  sensor reading, valid with sensor_ack
pid_set_temp  out  16 signed  latched setpoint to PID
pid_curr_temp  out  16 signed  latched reading to PID
pid_step  out  1  one-cycle PID advance pulse
pid_control  in  16 signed  PID output
duty_out  out  16  heater duty command
duty_valid  out  1  one-cycle pulse when duty_out updates
fault  out  1  high in FAULT state
overrun  out  1  sticky: tick arrived while iteration busy

Behaviour:
- Reset: state IDLE; all outputs 0; tick counter, timeout counter, settle counter and fault counter 0.
- Tick counter: runs only while enable=1 and state!=FAULT; counts 0..SAMPLE_PERIOD-1 and wraps; tick asserts in the wrap cycle. Held at 0 otherwise.
- IDLE: enable=1 -> WAIT_TICK next cycle.
- WAIT_TICK: on tick -> REQ; sensor_req=1 from the next cycle.
- REQ: sensor_req held high until sensor_ack is sampled high.
  - On ack: latch sensor_data->pid_curr_temp and set_temp_in->pid_set_temp; drop sensor_req next cycle; clear fault counter; -> STEP.
  - Timeout: TIMEOUT cycles without ack -> drop sensor_req and increment fault counter. Counter reaching MAX_FAULTS -> FAULT; otherwise -> WAIT_TICK.
  - ack and timeout in the same cycle: ack wins.
- STEP: pid_step=1 for exactly one cycle -> SETTLE.
- SETTLE: count PID_LAT cycles -> UPDATE.
- UPDATE: pid_control->duty_out, duty_valid=1 for one cycle -> WAIT_TICK.
- duty_out clamp: negative pid_control -> 0; otherwise passed through (0..32767).
- pid_set_temp/pid_curr_temp change only on ack capture; stable through STEP/SETTLE/UPDATE.
- sensor_ack outside REQ is ignored.
- Tick while state is REQ/STEP/SETTLE/UPDATE: tick dropped, overrun set sticky. overrun clears only on reset or fault_clr.
- FAULT: fault=1; duty_out forced 0 on entry (no duty_valid pulse); sensor_req=0; pid_step=0.
  - fault_clr -> IDLE next cycle; fault counter and overrun cleared.
  - enable has no effect in FAULT.
- enable=0 in any state except FAULT -> IDLE next cycle: sensor_req dropped, iteration abandoned, duty_out holds last value, no duty_valid.
- Reset mid-handshake: sensor_req drops immediately (async); state IDLE.

Test Plan (SAMPLE_PERIOD=20, PID_LAT=3, TIMEOUT=8, MAX_FAULTS=3):
- Nominal: enable=1, set_temp_in=500, ack 2 cycles after req with sensor_data=480, pid_control=20 -> pid inputs 500/480; pid_step single pulse; duty_valid 3 cycles after pid_step with duty_out=20; repeats every 20 cycles.
- Negative output: pid_control=-150 -> duty_out=0, duty_valid pulses.
- Timeout/fault: no ack for 3 periods -> sensor_req high 8 cycles each, drops; after 3rd timeout fault=1, duty_out=0. fault_clr -> IDLE, then nominal resumes. Single timeout followed by a good sample -> counter cleared, no fault.
- Ack/timeout collision: ack on 8th REQ cycle -> capture taken, no fault increment.
- Overrun: hold ack off 18 cycles with TIMEOUT=30 -> overrun=1 and stays 1 after later good iterations; exactly one pid_step per serviced tick.
- Disable/reset: enable=0 during SETTLE -> no duty_valid, duty_out unchanged, IDLE. Async reset during REQ -> sensor_req=0 same cycle, all outputs 0.
